time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Timekeeping and alarm core of the alarm clock. Sits directly upstream of the seven-segment display block.
- Divides the 100 MHz clock to a 1 Hz tick and counts seconds, minutes and hours in 24-hour time.
- Provides a button-driven set mode for the time and the alarm, and raises an alarm output on a time match.
- Drives a 16-bit binary {hours, minutes} word; BCD conversion happens downstream.

Parameters:
- CLK_HZ, 100000000, input clock frequency; prescaler terminal count is CLK_HZ-1.
- RING_SECS, 60, seconds the alarm rings before auto-off.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- btn_mode  in  1  debounced, synchronous level; a rising edge advances the set mode.
- btn_inc  in  1  debounced, synchronous level; a rising edge increments the selected field or acknowledges the alarm.
- alarm_en  in  1  level; 0 disables alarm matching and clears ringing.
- time_out  out  16  {hours[7:0], minutes[7:0]} in binary, values 0-23 and 0-59.
- sec_out  out  6  current seconds, 0-59.
- sec_pulse  out  1  one-cycle pulse on each 1 Hz tick.
- mode  out  3  current FSM state encoding.
- ring  out  1  alarm sounding.

Behaviour:
- Reset (rst=0, async):
  - All counters, the alarm hour/minute and the prescaler go to 0; FSM goes to RUN.
  - Edge-detect flops load 0; ring=0; sec_pulse=0; time_out=16'h0000.
  - Reset mid-operation aborts any set or ring immediately.
- Edge detect:
  - Each button is registered once and a rising edge is flagged when current=1 and previous=0.
  - Edge is valid 1 cycle after the input rises; a held button yields exactly one edge.
- Prescaler:
  - Counts 0..CLK_HZ-1 and emits a tick when it wraps to 0.
  - sec_pulse is a registered copy of the tick.
  - In SET_HR and SET_MIN the prescaler and seconds are held at 0.
- Time counters advance on tick:
  - sec 59->0 carries to min.
  - min 59->0 carries to hr.
  - hr 23->0 wraps.
  - All carries occur in the same cycle; 23:59:59 goes to 00:00:00 on one tick.
- FSM states: RUN=0, SET_HR=1, SET_MIN=2, SET_AHR=3, SET_AMIN=4.
  - A btn_mode edge moves RUN->SET_HR->SET_MIN->SET_AHR->SET_AMIN->RUN.
  - SET_HR: inc edge gives hr=(hr+1) mod 24.
  - SET_MIN: inc edge gives min=(min+1) mod 60; no carry into hours.
  - SET_AHR / SET_AMIN: inc edge increments alarm hour mod 24 / alarm minute mod 60; the time keeps running.
  - mode and inc edges in the same cycle: the mode edge wins and the inc edge is discarded.
- time_out content:
  - In SET_AHR and SET_AMIN it shows {alarm_hr, alarm_min}; otherwise {hr, min}.
  - Registered; updates the cycle after the counters change.
- Alarm match:
  - On a tick whose next state has sec=0, hr==alarm_hr and min==alarm_min, with alarm_en=1 and state not SET_HR/SET_MIN, ring goes to 1 the following cycle.
  - Manual setting never triggers the alarm.
- Ring termination:
  - ring clears on an inc edge in RUN (the edge does nothing else), on alarm_en=0 (next cycle), or after RING_SECS ticks.
  - The ring-seconds counter restarts from 0 at each match.
- Inc edges:
  - An inc edge in RUN with ring=0 is ignored.
  - An inc edge coinciding with a tick in a set state: both take effect; the increment applies to the post-tick value.
- Arithmetic: hours and minutes are held in 5/6-bit registers and zero-extended to 8 bits on time_out.

Decomposition:
- Shared package holds:
  - FSM state encodings (3 bits).
  - Constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - Field widths: 6, 6, 5.
- One sub-module, btn_edge: a synchronous rising-edge detector with async active-low reset, instantiated for btn_mode and btn_inc.

Test Plan (CLK_HZ=10 for simulation):
- Reset: hold rst=0 mid-count, release -> time_out=16'h0000, sec_out=0, ring=0, mode=0; first sec_pulse 10 cycles after release.
- Rollover: set 23:59, run 60 ticks -> time_out goes 0x173B -> 0x0000 on the single tick where sec 59->0; no intermediate value.
- Set time: mode edge, 5 inc edges, mode edge, 61 inc edges -> hr=5, min=1 (wraps, no hour carry); sec_out stays 0 during SET states.
- Simultaneous events: mode and inc rise in the same cycle in SET_HR -> state goes to SET_MIN, hr unchanged.
- Alarm: alarm=00:02, alarm_en=1, run from 00:00:00 -> ring=1 one cycle after the tick reaching 00:02:00; inc edge clears ring with no time change. Re-run without an inc edge -> ring auto-clears after 60 ticks.
- Alarm gating: alarm_en=0 at match -> ring stays 0. Manually set time to the alarm time -> ring stays 0. Drop alarm_en while ringing -> ring=0 next cycle.

Source files
------------

// File: rtl/time_keeper_pkg.sv
// Shared types and constants for the alarm-clock timekeeper.
// Field widths, wrap limits and set-mode state encodings.
package time_keeper_pkg;

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      SET_HR   = 3'd1,
      SET_MIN  = 3'd2,
      SET_AHR  = 3'd3,
      SET_AMIN = 3'd4
   } state_t;

   localparam int SEC_W = 6;
   localparam int MIN_W = 6;
   localparam int HR_W  = 5;

   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
   localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

endpackage

// File: rtl/time_keeper_if.sv
// Button/alarm inputs and display-side outputs of the timekeeper.
// master drives the buttons, slave is the timekeeper itself.
interface time_keeper_if;

   logic        btn_mode;
   logic        btn_inc;
   logic        alarm_en;
   logic [15:0] time_out;
   logic [5:0]  sec_out;
   logic        sec_pulse;
   logic [2:0]  mode;
   logic        ring;

   modport master (
      output btn_mode, btn_inc, alarm_en,
      input  time_out, sec_out, sec_pulse, mode, ring
   );

   modport slave (
      input  btn_mode, btn_inc, alarm_en,
      output time_out, sec_out, sec_pulse, mode, ring
   );

endinterface

// File: rtl/time_keeper_btn_edge.sv
// Rising-edge detector for a debounced, synchronous button level.
// The edge flag is registered, so it is valid the cycle after the rise.
module time_keeper_btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_edge
);

   logic r_prev;
   logic r_edge;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev <= 1'b0;
         r_edge <= 1'b0;
      end else begin
         r_prev <= i_btn;
         r_edge <= i_btn & ~r_prev;
      end
   end

   assign o_edge = r_edge;

endmodule

// File: rtl/time_keeper.sv
// 24-hour timekeeper with button-driven time/alarm setting and a
// self-limiting alarm ring output.
module time_keeper
   import time_keeper_pkg::*;
#(
   parameter int CLK_HZ    = 100000000,
   parameter int RING_SECS = 60
) (
   input  logic          clk,
   input  logic          rst,
   time_keeper_if.slave  bus
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
   localparam logic [PW-1:0] P_TOP = PW'(CLK_HZ - 1);
   localparam logic [RW-1:0] R_TOP = RW'(RING_SECS - 1);

   state_t           r_state, w_state_n;
   logic [PW-1:0]    r_presc, w_presc_n;
   logic [SEC_W-1:0] r_sec, w_sec_n;
   logic [MIN_W-1:0] r_min, w_min_n;
   logic [HR_W-1:0]  r_hr, w_hr_n;
   logic [MIN_W-1:0] r_amin, w_amin_n;
   logic [HR_W-1:0]  r_ahr, w_ahr_n;
   logic [RW-1:0]    r_rcnt, w_rcnt_n;
   logic             r_ring, w_ring_n;
   logic             r_pulse;
   logic [15:0]      r_time;
   logic             w_mode_e, w_inc_e;
   logic             w_hold, w_hold_n;
   logic             w_tick, w_match;

   time_keeper_btn_edge u_mode_edge (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (bus.btn_mode),
      .o_edge (w_mode_e)
   );

   time_keeper_btn_edge u_inc_edge (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (bus.btn_inc),
      .o_edge (w_inc_e)
   );

   always_comb begin
      w_hold    = (r_state == SET_HR) || (r_state == SET_MIN);
      w_tick    = !w_hold && (r_presc == P_TOP);
      w_presc_n = w_tick ? '0 : r_presc + 1'b1;
      w_sec_n   = r_sec;
      w_min_n   = r_min;
      w_hr_n    = r_hr;
      w_state_n = r_state;
      w_ahr_n   = r_ahr;
      w_amin_n  = r_amin;
      w_ring_n  = r_ring;
      w_rcnt_n  = r_rcnt;

      // full sec/min/hr carry chain resolves within one tick
      if (w_tick) begin
         if (r_sec == SEC_MAX) begin
            w_sec_n = '0;
            if (r_min == MIN_MAX) begin
               w_min_n = '0;
               w_hr_n  = (r_hr == HR_MAX) ? '0 : r_hr + 1'b1;
            end else begin
               w_min_n = r_min + 1'b1;
            end
         end else begin
            w_sec_n = r_sec + 1'b1;
         end
      end

      w_match = w_tick && bus.alarm_en && (w_sec_n == '0) &&
                (w_hr_n == r_ahr) && (w_min_n == r_amin);

      if (r_ring && w_tick) begin
         w_rcnt_n = r_rcnt + 1'b1;
         if (r_rcnt == R_TOP) w_ring_n = 1'b0;
      end

      if (w_mode_e) begin
         unique case (r_state)
            RUN:      w_state_n = SET_HR;
            SET_HR:   w_state_n = SET_MIN;
            SET_MIN:  w_state_n = SET_AHR;
            SET_AHR:  w_state_n = SET_AMIN;
            default:  w_state_n = RUN;
         endcase
      end else if (w_inc_e) begin
         unique case (r_state)
            RUN:      w_ring_n = 1'b0;
            SET_HR:   w_hr_n = (w_hr_n == HR_MAX) ? '0 : w_hr_n + 1'b1;
            SET_MIN:  w_min_n = (w_min_n == MIN_MAX) ? '0 : w_min_n + 1'b1;
            SET_AHR:  w_ahr_n = (r_ahr == HR_MAX) ? '0 : r_ahr + 1'b1;
            default:  w_amin_n = (r_amin == MIN_MAX) ? '0 : r_amin + 1'b1;
         endcase
      end

      if (w_match) begin
         w_ring_n = 1'b1;
         w_rcnt_n = '0;
      end
      if (!bus.alarm_en) w_ring_n = 1'b0;

      w_hold_n = (w_state_n == SET_HR) || (w_state_n == SET_MIN);
      if (w_hold_n) begin
         w_presc_n = '0;
         w_sec_n   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
         r_presc <= '0;
         r_sec   <= '0;
         r_min   <= '0;
         r_hr    <= '0;
         r_amin  <= '0;
         r_ahr   <= '0;
         r_rcnt  <= '0;
         r_ring  <= 1'b0;
         r_pulse <= 1'b0;
         r_time  <= 16'h0000;
      end else begin
         r_state <= w_state_n;
         r_presc <= w_presc_n;
         r_sec   <= w_sec_n;
         r_min   <= w_min_n;
         r_hr    <= w_hr_n;
         r_amin  <= w_amin_n;
         r_ahr   <= w_ahr_n;
         r_rcnt  <= w_rcnt_n;
         r_ring  <= w_ring_n;
         r_pulse <= w_tick;
         if ((r_state == SET_AHR) || (r_state == SET_AMIN))
            r_time <= {3'b000, r_ahr, 2'b00, r_amin};
         else
            r_time <= {3'b000, r_hr, 2'b00, r_min};
      end
   end

   assign bus.time_out  = r_time;
   assign bus.sec_out   = r_sec;
   assign bus.sec_pulse = r_pulse;
   assign bus.mode      = r_state;
   assign bus.ring      = r_ring;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed tables and sequences plus random
// button traffic, all checked against a seconds-of-day reference model.
module tb_time_keeper;

   localparam int CLK_HZ = 10;
   localparam int RING   = 60;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_mode = 1'b0;
   logic btn_inc = 1'b0;
   logic alarm_en = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   int ring_cyc = 0;

   time_keeper_if bus ();
   assign bus.btn_mode = btn_mode;
   assign bus.btn_inc  = btn_inc;
   assign bus.alarm_en = alarm_en;

   time_keeper #(.CLK_HZ(CLK_HZ), .RING_SECS(RING)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model: time of day as plain seconds since midnight
   typedef struct {
      int tod;
      int ahr;
      int amin;
      int st;
      int left;
      int ph;
      int tout;
      bit ring;
      bit pulse;
   } mdl_t;

   mdl_t m;
   bit mh1, mh2, ih1, ih2;

   function automatic mdl_t step(mdl_t c, bit me, bit ie, bit en);
      mdl_t n = c;
      bit hold, tk;
      int t1, h, mi;
      hold = (c.st == 1) || (c.st == 2);
      tk = !hold && (c.ph == CLK_HZ - 1);
      n.pulse = tk;
      n.tout = (c.st >= 3) ? (c.ahr * 256 + c.amin)
                           : ((c.tod / 3600) * 256 + (c.tod / 60) % 60);
      t1 = tk ? (c.tod + 1) % 86400 : c.tod;
      n.tod = t1;
      if (c.ring && tk) begin
         n.left = c.left - 1;
         if (n.left == 0) n.ring = 1'b0;
      end
      if (me) n.st = (c.st + 1) % 5;
      else if (ie) begin
         case (c.st)
            0: n.ring = 1'b0;
            1: begin
               h = (n.tod / 3600 + 1) % 24;
               n.tod = h * 3600 + n.tod % 3600;
            end
            2: begin
               mi = ((n.tod / 60) % 60 + 1) % 60;
               n.tod = (n.tod / 3600) * 3600 + mi * 60 + n.tod % 60;
            end
            3: n.ahr = (c.ahr + 1) % 24;
            default: n.amin = (c.amin + 1) % 60;
         endcase
      end
      if (tk && en && (t1 % 60 == 0) && (t1 / 3600 == c.ahr) &&
          ((t1 / 60) % 60 == c.amin)) begin
         n.ring = 1'b1;
         n.left = RING;
      end
      if (!en) n.ring = 1'b0;
      if ((n.st == 1) || (n.st == 2)) begin
         n.ph = 0;
         n.tod = n.tod - n.tod % 60;
      end else begin
         n.ph = tk ? 0 : c.ph + 1;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m <= '{default: 0};
         mh1 <= 1'b0; mh2 <= 1'b0;
         ih1 <= 1'b0; ih2 <= 1'b0;
      end else begin
         m <= step(m, mh1 && !mh2, ih1 && !ih2, alarm_en);
         mh1 <= btn_mode; mh2 <= mh1;
         ih1 <= btn_inc;  ih2 <= ih1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("mdl_tout",  int'(bus.time_out),  m.tout);
         chk("mdl_sec",   int'(bus.sec_out),   m.tod % 60);
         chk("mdl_pulse", int'(bus.sec_pulse), int'(m.pulse));
         chk("mdl_mode",  int'(bus.mode),      m.st);
         chk("mdl_ring",  int'(bus.ring),      int'(m.ring));
      end
   end

   always @(negedge clk) if (bus.ring) ring_cyc <= ring_cyc + 1;

   task automatic press(input bit which, input int n);
      repeat (n) begin
         @(negedge clk);
         if (which) btn_inc = 1'b1; else btn_mode = 1'b1;
         repeat (2) @(negedge clk);
         btn_inc = 1'b0;
         btn_mode = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wait_ring(input bit lvl, input int budget, output int cyc);
      cyc = 0;
      while ((bus.ring !== lvl) && (cyc < budget)) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   typedef struct {
      int n_mode;
      int n_inc;
      int exp_mode;
      int exp_tout;
      bit sec0;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, cyc, cnt, snap, prev, newv;
      vecs[0] = '{1, 5,  1, 16'h0500, 1'b1};
      vecs[1] = '{1, 61, 2, 16'h0501, 1'b1};
      vecs[2] = '{1, 7,  3, 16'h0700, 1'b0};
      vecs[3] = '{1, 30, 4, 16'h071E, 1'b0};
      vecs[4] = '{1, 0,  0, 16'h0501, 1'b0};
      vecs[5] = '{5, 0,  0, 16'h0501, 1'b0};
      vecs[6] = '{2, 0,  2, 16'h0501, 1'b1};
      vecs[7] = '{0, 3,  2, 16'h0504, 1'b1};
      vecs[8] = '{3, 0,  0, 16'h0504, 1'b0};

      // reset, then async reset in the middle of a count
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b1;
      repeat (37) @(negedge clk);
      #3 rst = 1'b0;
      #1;
      chk("rst_tout", int'(bus.time_out), 0);
      chk("rst_sec",  int'(bus.sec_out), 0);
      chk("rst_ring", int'(bus.ring), 0);
      chk("rst_mode", int'(bus.mode), 0);
      chk("rst_pulse", int'(bus.sec_pulse), 0);
      @(negedge clk);
      rst = 1'b1;
      k = 0;
      while (k < 20) begin
         @(posedge clk);
         #1;
         k++;
         if (bus.sec_pulse) break;
      end
      chk("first_pulse_cycles", k, 10);

      // table of set-mode steps
      for (int i = 0; i < 9; i++) begin
         press(1'b0, vecs[i].n_mode);
         press(1'b1, vecs[i].n_inc);
         repeat (2) @(negedge clk);
         chk($sformatf("vec%0d_mode", i), int'(bus.mode), vecs[i].exp_mode);
         chk($sformatf("vec%0d_tout", i), int'(bus.time_out), vecs[i].exp_tout);
         if (vecs[i].sec0)
            chk($sformatf("vec%0d_sec0", i), int'(bus.sec_out), 0);
      end

      // mode and inc rising together in SET_HR
      press(1'b0, 1);
      @(negedge clk);
      btn_mode = 1'b1; btn_inc = 1'b1;
      repeat (2) @(negedge clk);
      btn_mode = 1'b0; btn_inc = 1'b0;
      repeat (2) @(negedge clk);
      chk("simul_mode", int'(bus.mode), 2);
      chk("simul_tout", int'(bus.time_out), 16'h0504);
      press(1'b0, 3);
      chk("simul_back_run", int'(bus.mode), 0);

      // 23:59 rollover
      press(1'b0, 1);
      press(1'b1, 18);
      press(1'b0, 1);
      press(1'b1, 55);
      repeat (2) @(negedge clk);
      chk("roll_set", int'(bus.time_out), 16'h173B);
      press(1'b0, 3);
      prev = int'(bus.time_out);
      newv = prev;
      cyc = 0;
      while ((newv == prev) && (cyc < 800)) begin
         @(negedge clk);
         cyc++;
         newv = int'(bus.time_out);
      end
      chk("roll_from", prev, 16'h173B);
      chk("roll_to", newv, 16'h0000);
      chk("roll_sec", int'(bus.sec_out), 0);

      // alarm at 00:02, acknowledged by inc
      alarm_en = 1'b1;
      press(1'b0, 3);
      press(1'b1, 17);
      press(1'b0, 1);
      press(1'b1, 32);
      press(1'b0, 1);
      wait_ring(1'b1, 2000, cyc);
      chk("alm_rise", int'(bus.ring), 1);
      chk("alm_rise_sec", int'(bus.sec_out), 0);
      @(negedge clk);
      chk("alm_time", int'(bus.time_out), 16'h0002);
      press(1'b1, 1);
      chk("alm_ack_ring", int'(bus.ring), 0);
      chk("alm_ack_time", int'(bus.time_out), 16'h0002);
      chk("alm_ack_mode", int'(bus.mode), 0);

      // alarm at 00:03, auto-off after RING ticks
      press(1'b0, 4);
      press(1'b1, 1);
      press(1'b0, 1);
      wait_ring(1'b1, 1000, cyc);
      chk("auto_rise", int'(bus.ring), 1);
      cnt = 0;
      cyc = 0;
      while (cyc < 700) begin
         @(negedge clk);
         cyc++;
         if (bus.sec_pulse) cnt++;
         if (!bus.ring) break;
      end
      chk("auto_ticks", cnt, RING);
      chk("auto_off", int'(bus.ring), 0);

      // match with alarm disabled
      alarm_en = 1'b0;
      press(1'b0, 4);
      press(1'b1, 2);
      press(1'b0, 1);
      snap = ring_cyc;
      cyc = 0;
      while ((int'(bus.time_out) != 16'h0005) && (cyc < 1000)) begin
         @(negedge clk);
         cyc++;
      end
      repeat (20) @(negedge clk);
      chk("dis_reached", int'(bus.time_out), 16'h0005);
      chk("dis_no_ring", ring_cyc - snap, 0);

      // manual set onto the alarm time
      alarm_en = 1'b1;
      snap = ring_cyc;
      press(1'b0, 2);
      press(1'b1, 1);
      press(1'b0, 2);
      press(1'b1, 1);
      press(1'b0, 1);
      repeat (100) @(negedge clk);
      chk("man_time", int'(bus.time_out), 16'h0006);
      chk("man_no_ring", ring_cyc - snap, 0);

      // drop alarm_en while ringing
      press(1'b0, 4);
      press(1'b1, 1);
      press(1'b0, 1);
      wait_ring(1'b1, 1000, cyc);
      chk("drop_rise", int'(bus.ring), 1);
      repeat (5) @(negedge clk);
      alarm_en = 1'b0;
      @(negedge clk);
      chk("drop_ring", int'(bus.ring), 0);
      alarm_en = 1'b1;

      // random button traffic against the model
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 3) btn_mode = ~btn_mode;
         if ($urandom_range(0, 99) < 10) btn_inc = ~btn_inc;
         if ($urandom_range(0, 999) < 5) alarm_en = ~alarm_en;
      end
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
